// File: rtl/shift_deserializer_pkg.sv
// Shared definitions for the shift_deserializer capture stage: default frame
// width, FSM state encoding and the bit-counter width helper.
package shift_deserializer_pkg;

  localparam int unsigned DefWidth = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StParity = 2'd2
  } state_e;

  // Counter must be able to hold WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_deserializer_sipo_reg.sv
// sipo_reg: WIDTH-bit serial-in/parallel-out shift register, MSB first,
// with shift enable and asynchronous clear.
module shift_deserializer_sipo_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  // Shift new bit in at the LSB; the first bit of a frame ends up at the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= {q[WIDTH-2:0], sin};
    end
  end

endmodule

// File: rtl/shift_deserializer.sv
// shift_deserializer: serial-in/parallel-out capture stage for the MSB-first
// stream from shift_left. Reassembles WIDTH-bit words, presents them with a
// valid/ready handshake and flags a sticky overrun when a completed word has
// to be dropped. Optional feature macro: PARITY_CHECK_EN (one trailing even
// parity bit per frame, reported on parity_err).
module shift_deserializer
  import shift_deserializer_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sin,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic             parity_err
);

  localparam int unsigned    CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
`ifdef PARITY_CHECK_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] word;
  logic             shift_en;
  logic             frame_done;
  logic             commit;
  logic             load;

  shift_deserializer_sipo_reg #(
    .WIDTH (WIDTH)
  ) u_sipo_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (shift_en),
    .sin   (sin),
    .q     (sr_q)
  );

  // Last data bit is on sin this cycle (a start would abort the frame instead).
  assign frame_done = (state_q == StShift) && !start && (cnt_q == LastCnt);

  // In SHIFT the final data bit is still on sin; in PARITY the word is already in sr_q.
  assign word = (state_q == StParity) ? sr_q : {sr_q[WIDTH-2:0], sin};

  // A commit lands only if the output slot is free or being emptied this cycle.
  assign load = commit && (!dout_valid || dout_ready);

  assign busy = (state_q != StIdle);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start always (re)starts a frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StShift;
      StShift:  if (frame_done) state_d = ParityEn ? StParity : StIdle;
      StParity: state_d = start ? StShift : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs: shift enable, bit counter next value and word commit.
  always_comb begin
    shift_en = 1'b0;
    commit   = 1'b0;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          shift_en = 1'b1;
          cnt_d    = CntW'(1);
        end
      end
      StShift: begin
        shift_en = 1'b1;
        if (start) begin
          cnt_d = CntW'(1);
        end else if (frame_done) begin
          cnt_d  = ParityEn ? CntW'(WIDTH) : '0;
          commit = !ParityEn;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StParity: begin
        if (start) begin
          shift_en = 1'b1;
          cnt_d    = CntW'(1);
        end else begin
          cnt_d  = '0;
          commit = 1'b1;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // Bit counter, output word register, handshake and sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (load) begin
        dout       <= word;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
      // A new drop wins over a simultaneous clear.
      overrun <= (overrun && !overrun_clr) || (commit && !load);
    end
  end

`ifdef PARITY_CHECK_EN
  // Even parity over data plus parity bit; only refreshed when a word commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else if (load) begin
      parity_err <= ^{sr_q, sin};
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
